output_port_demux: RTL and testbench

- Egress-side counterpart of the input arbiter: takes the single merged packet stream (data/ctrl/wr/rdy) and steers each packet to one or more of NUM_QUEUES output queues.
- Steering uses the one-hot destination mask in the packet's leading module-header word.
- Sits between the final user-datapath stage and the output queues.
- Supports multicast (several mask bits set), per-queue back-pressure, and drop of unroutable or malformed packets, with counters.

---
 rtl/output_port_demux.sv | 129 ++++++++++++
 tb/tb_output_port_demux.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/output_port_demux.sv
// output_port_demux: steers the merged egress packet stream to one or more output queues.
//   clk, reset (sync, active-low)
//   in_data/in_ctrl/in_wr/in_rdy : merged input stream, in_rdy allows one extra write after deassert
//   out_data/out_ctrl            : registered word shared by every queue
//   out_wr/out_rdy               : per-queue write strobe and ready
//   drop_cnt                     : packets discarded for a zero destination mask
//   malformed_cnt                : non-header words discarded while waiting for a header
module output_port_demux #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_QUEUES = 8,
    parameter logic [CTRL_WIDTH-1:0] HDR_CTRL = 8'hFF,
    parameter int DST_POS = 16,
    parameter int BUF_DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [NUM_QUEUES-1:0] out_wr,
    input  logic [NUM_QUEUES-1:0] out_rdy,
    output logic [31:0]           drop_cnt,
    output logic [31:0]           malformed_cnt
);
    localparam int DEPTH = 1 << BUF_DEPTH_BITS;
    localparam logic [BUF_DEPTH_BITS:0] FULL_LVL = (BUF_DEPTH_BITS + 1)'(DEPTH);
    localparam logic [BUF_DEPTH_BITS:0] NF_LVL = (BUF_DEPTH_BITS + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

    logic [DATA_WIDTH-1:0]   mem_data [DEPTH];
    logic [CTRL_WIDTH-1:0]   mem_ctrl [DEPTH];
    logic [BUF_DEPTH_BITS-1:0] rd_ptr, wr_ptr;
    logic [BUF_DEPTH_BITS:0] count;
    logic                    empty, full, push, pop;
    logic [DATA_WIDTH-1:0]   head_data;
    logic [CTRL_WIDTH-1:0]   head_ctrl;
    logic [NUM_QUEUES-1:0]   head_mask, mask;
    logic [CTRL_WIDTH-1:0]   prev_ctrl;
    logic                    is_hdr, go, eop, fwd, latch, drop_inc, mal_inc;
    state_t                  state, state_nxt;

    // first-word-fall-through buffer: head word is visible whenever not empty
    assign empty     = count == '0;
    assign full      = count == FULL_LVL;
    assign in_rdy    = count < NF_LVL;
    assign push      = in_wr && !full;
    assign head_data = mem_data[rd_ptr];
    assign head_ctrl = mem_ctrl[rd_ptr];
    assign head_mask = head_data[DST_POS +: NUM_QUEUES];
    assign is_hdr    = head_ctrl == HDR_CTRL;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= in_data;
            mem_ctrl[wr_ptr] <= in_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (BUF_DEPTH_BITS + 1)'(push) - (BUF_DEPTH_BITS + 1)'(pop);
        end
    end

    // a word may leave only when every queue it targets can take it
    assign go  = !empty && &(out_rdy | ~mask);
    // end of packet: first non-zero ctrl following a body word
    assign eop = (head_ctrl != '0) && (prev_ctrl == '0);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!empty && is_hdr) state_nxt = (head_mask != '0) ? PKT : DROP;
            PKT:     if (go && eop) state_nxt = IDLE;
            DROP:    if (!empty && eop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fwd      = state == PKT && go;
        latch    = state == IDLE && !empty && is_hdr && head_mask != '0;
        drop_inc = state == IDLE && !empty && is_hdr && head_mask == '0;
        mal_inc  = state == IDLE && !empty && !is_hdr;
        pop      = fwd || mal_inc || (state == DROP && !empty);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_wr        <= '0;
            out_data      <= '0;
            out_ctrl      <= '0;
            mask          <= '0;
            prev_ctrl     <= HDR_CTRL;
            drop_cnt      <= '0;
            malformed_cnt <= '0;
        end else begin
            out_wr <= fwd ? mask : '0;
            if (fwd) begin
                out_data <= head_data;
                out_ctrl <= head_ctrl;
            end
            if (latch) begin
                mask      <= head_mask;
                prev_ctrl <= HDR_CTRL;
            end
            // discarded malformed words do not take part in packet framing
            if (pop && state != IDLE) prev_ctrl <= head_ctrl;
            drop_cnt      <= drop_cnt + 32'(drop_inc);
            malformed_cnt <= malformed_cnt + 32'(mal_inc);
        end
    end
endmodule

// File: tb/tb_output_port_demux.sv
// tb_output_port_demux: scoreboard bench for output_port_demux.
module tb_output_port_demux;
    logic        clk = 0;
    logic        reset = 0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 0;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic [7:0]  out_wr;
    logic [7:0]  out_rdy = '1;
    logic [31:0] drop_cnt, malformed_cnt;

    typedef struct {
        logic [7:0]  m;
        logic [63:0] d;
        logic [7:0]  c;
        int          exp_cyc;
        bit          gap2;
    } entry_t;

    entry_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_wr = 0;
    bit saw_busy = 0;
    bit abort = 0;

    output_port_demux dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .drop_cnt(drop_cnt), .malformed_cnt(malformed_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!in_rdy) saw_busy = 1;
        if (reset && out_wr != '0) begin
            if (exp_q.size() == 0) begin
                check("extra_wr", 64'(out_wr), 64'(0));
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                check("wr_mask", 64'(out_wr), 64'(e.m));
                check("data", out_data, e.d);
                check("ctrl", 64'(out_ctrl), 64'(e.c));
                if (e.exp_cyc >= 0) check("latency", 64'(cyc), 64'(e.exp_cyc));
                if (e.gap2) check("gap", 64'(cyc), 64'(last_wr + 2));
            end
            last_wr = cyc;
        end
    end

    // drives one packet; called and returns at posedge+1
    task automatic send(input logic [7:0] m, input int nhdr, input int nbody, input logic [7:0] ectrl,
                        input bit route, input bit lat, input bit gap_first);
        logic [63:0] wd[$];
        logic [7:0]  wc[$];
        int t0;
        for (int i = 0; i < nhdr; i++) begin
            wd.push_back({32'($urandom), 8'h00, m, 16'(i)});
            wc.push_back(8'hFF);
        end
        for (int i = 0; i < nbody; i++) begin
            wd.push_back({32'($urandom), 32'($urandom)});
            wc.push_back(8'h00);
        end
        if (ectrl != 0) begin
            wd.push_back({32'($urandom), 32'($urandom)});
            wc.push_back(ectrl);
        end
        t0 = cyc;
        for (int j = 0; j < wd.size(); j++) begin
            int w = 0;
            while (!in_rdy && !abort && w < 200) begin
                in_wr = 0;
                @(posedge clk) #1;
                w++;
            end
            if (w >= 200) begin
                check("rdy_timeout", 64'(0), 64'(1));
                break;
            end
            if (abort) break;
            in_data = wd[j];
            in_ctrl = wc[j];
            in_wr = 1;
            if (route) exp_q.push_back('{m, wd[j], wc[j], lat ? t0 + 3 + j : -1, gap_first && j == 0});
            @(posedge clk) #1;
        end
        in_wr = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_out();
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_wr != 0) break;
        end
        if (i >= 100) check("out_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_wr", 64'(out_wr), 64'(0));
        check("rst_out_data", out_data, 64'(0));
        check("rst_out_ctrl", 64'(out_ctrl), 64'(0));
        check("rst_drop", 64'(drop_cnt), 64'(0));
        check("rst_mal", 64'(malformed_cnt), 64'(0));
        check("rst_in_rdy", 64'(in_rdy), 64'(1));
        @(posedge clk) #1;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;

        send(8'h04, 2, 3, 8'h10, 1, 1, 0);
        drain();
        check("t1_drop", 64'(drop_cnt), 64'(0));

        fork
            send(8'h81, 1, 10, 8'h20, 1, 0, 0);
            begin
                wait_out();
                repeat (2) @(posedge clk);
                #1 out_rdy[7] = 0;
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk) #1;
                    if (k == 4) out_rdy[7] = 1;
                    @(negedge clk);
                    check("stall_wr", 64'(out_wr), 64'(0));
                end
            end
        join
        drain();

        send(8'h00, 1, 2, 8'h30, 0, 0, 0);
        send(8'h02, 1, 2, 8'h40, 1, 0, 0);
        drain();
        check("t3_drop", 64'(drop_cnt), 64'(1));

        send(8'h00, 0, 2, 8'h00, 0, 0, 0);
        send(8'h08, 1, 1, 8'h50, 1, 0, 0);
        drain();
        check("t4_mal", 64'(malformed_cnt), 64'(2));
        check("t4_drop", 64'(drop_cnt), 64'(1));

        saw_busy = 0;
        send(8'h01, 1, 6, 8'h11, 1, 0, 0);
        send(8'h20, 1, 6, 8'h22, 1, 0, 1);
        drain();
        check("t5_busy", 64'(saw_busy), 64'(1));

        fork
            send(8'h04, 1, 10, 8'h60, 1, 0, 0);
            begin
                wait_out();
                @(posedge clk) #2;
                abort = 1;
                reset = 0;
                in_wr = 0;
                @(posedge clk) #1;
                reset = 1;
                exp_q.delete();
                @(negedge clk);
                check("rst_mid_wr", 64'(out_wr), 64'(0));
                check("rst_mid_drop", 64'(drop_cnt), 64'(0));
                check("rst_mid_mal", 64'(malformed_cnt), 64'(0));
            end
        join
        abort = 0;
        repeat (3) @(posedge clk);
        #1;
        send(8'h04, 1, 2, 8'h70, 1, 0, 0);
        drain();
        check("t6_drop", 64'(drop_cnt), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
